// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run/pix_en controls toward the generator, timing outputs back.
// master = generator side, slave = consumer side.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int CW      = 10,
  parameter int FRAME_W = 8
);
  logic               run;
  logic               pix_en;
  logic               h_sync;
  logic               v_sync;
  logic               display_on;
  logic [CW-1:0]      pixel_x;
  logic [CW-1:0]      pixel_y;
  logic               line_start;
  logic               frame_start;
  logic               vblank;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  run, pix_en,
    output h_sync, v_sync, display_on, pixel_x, pixel_y,
           line_start, frame_start, vblank, frame_count
  );

  modport slave (
    output run, pix_en,
    input  h_sync, v_sync, display_on, pixel_x, pixel_y,
           line_start, frame_start, vblank, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; every output is a register describing the pixel
// presented that cycle (one edge after run/pix_en). pix_en=0 holds position; run=0 parks at (0,0).
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CW       = 10,
  parameter int   FRAME_W  = 8
) (
  input  logic             clock25,
  input  logic             reset,
  vga_timing_gen_if.master tim
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)) begin : g_cw_too_narrow
      $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  // Sync windows as inclusive ranges so a zero back porch cannot overflow CW.
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [FRAME_W-1:0] FC_ONE = FRAME_W'(1);

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      x_q, x_d, y_q, y_d;
  logic [CW-1:0]      x_nxt, y_nxt;
  logic               h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic               display_on_q, display_on_d, vblank_q, vblank_d;
  logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    x_nxt         = x_q;
    y_nxt         = y_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    display_on_d  = display_on_q;
    vblank_d      = vblank_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;

    if (!tim.run) begin
      state_d      = ST_STOPPED;
      x_d          = '0;
      y_d          = '0;
      h_sync_d     = ~H_POL;
      v_sync_d     = ~V_POL;
      display_on_d = 1'b0;
      vblank_d     = 1'b0;
    end else if (tim.pix_en) begin
      state_d = ST_RUNNING;
      if (state_q == ST_STOPPED) begin
        x_nxt = '0;
        y_nxt = '0;
      end else if (x_q == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == V_LAST) ? '0 : y_q + ONE;
      end else begin
        x_nxt = x_q + ONE;
      end
      x_d           = x_nxt;
      y_d           = y_nxt;
      h_sync_d      = (x_nxt >= HS_BEG && x_nxt <= HS_LAST) ? H_POL : ~H_POL;
      v_sync_d      = (y_nxt >= VS_BEG && y_nxt <= VS_LAST) ? V_POL : ~V_POL;
      display_on_d  = (x_nxt < H_ACT) && (y_nxt < V_ACT);
      vblank_d      = (y_nxt >= V_ACT);
      line_start_d  = (x_nxt == '0);
      frame_start_d = (x_nxt == '0) && (y_nxt == '0);
      if (frame_start_d) begin
        frame_count_d = frame_count_q + FC_ONE;
      end
    end
  end

  always_ff @(posedge clock25 or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_STOPPED;
      x_q           <= '0;
      y_q           <= '0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      display_on_q  <= 1'b0;
      vblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      display_on_q  <= display_on_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tim.pixel_x     = x_q;
  assign tim.pixel_y     = y_q;
  assign tim.h_sync      = h_sync_q;
  assign tim.v_sync      = v_sync_q;
  assign tim.display_on  = display_on_q;
  assign tim.vblank      = vblank_q;
  assign tim.line_start  = line_start_q;
  assign tim.frame_start = frame_start_q;
  assign tim.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Drives a default-size and a tiny generator with shared stimulus; each is compared every
// cycle against a frame-index model (position = pixel number within the frame).
`timescale 1ns/1ps
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic pix_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_period = 0;
  int last_ls = -1;

  vga_timing_gen_if #(.CW(10), .FRAME_W(8)) ifa ();
  vga_timing_gen_if #(.CW(4),  .FRAME_W(8)) ifb ();

  assign ifa.run    = run;
  assign ifa.pix_en = pix_en;
  assign ifb.run    = run;
  assign ifb.pix_en = pix_en;

  vga_timing_gen u_dut_a (
    .clock25 (clk),
    .reset   (rst_n),
    .tim     (ifa.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .CW(4), .FRAME_W(8)
  ) u_dut_b (
    .clock25 (clk),
    .reset   (rst_n),
    .tim     (ifb.master)
  );

  always #5 clk = ~clk;

  // Timing description per instance: index 0 = defaults, 1 = tiny raster.
  int ha  [2] = '{640, 4};
  int hf  [2] = '{16, 1};
  int hsw [2] = '{96, 2};
  int hb  [2] = '{48, 1};
  int va  [2] = '{480, 3};
  int vf  [2] = '{10, 1};
  int vsw [2] = '{2, 1};
  int vbp [2] = '{33, 1};
  int hpol[2] = '{0, 1};
  int vpol[2] = '{0, 0};

  int m_run[2];
  int m_p  [2];
  int m_fc [2];
  int m_ls [2];
  int m_fs [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_p[d] = 0; m_fc[d] = 0; m_ls[d] = 0; m_fs[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit r, input bit pe);
    int ht, vt;
    ht = ha[d] + hf[d] + hsw[d] + hb[d];
    vt = va[d] + vf[d] + vsw[d] + vbp[d];
    if (!r) begin
      m_run[d] = 0; m_p[d] = 0; m_ls[d] = 0; m_fs[d] = 0;
    end else if (pe) begin
      if (m_run[d] == 0) begin
        m_run[d] = 1;
        m_p[d] = 0;
      end else begin
        m_p[d] = (m_p[d] + 1) % (ht * vt);
      end
      m_ls[d] = (m_p[d] % ht == 0) ? 1 : 0;
      m_fs[d] = (m_p[d] == 0) ? 1 : 0;
      if (m_fs[d] != 0) m_fc[d] = (m_fc[d] + 1) % 256;
    end else begin
      m_ls[d] = 0; m_fs[d] = 0;
    end
  endtask

  task automatic check_dut(input int d);
    int ht, ex, ey, ehs, evs, ede, evb;
    int ox, oy, ohs, ovs, ode, ovb, ols, ofs, ofc;
    string p;
    ht  = ha[d] + hf[d] + hsw[d] + hb[d];
    ex  = m_p[d] % ht;
    ey  = m_p[d] / ht;
    ehs = (m_run[d] != 0 && ex >= ha[d] + hf[d] && ex < ha[d] + hf[d] + hsw[d]) ? hpol[d] : 1 - hpol[d];
    evs = (m_run[d] != 0 && ey >= va[d] + vf[d] && ey < va[d] + vf[d] + vsw[d]) ? vpol[d] : 1 - vpol[d];
    ede = (m_run[d] != 0 && ex < ha[d] && ey < va[d]) ? 1 : 0;
    evb = (ey >= va[d]) ? 1 : 0;
    if (d == 0) begin
      p = "a";
      ox = int'(ifa.pixel_x); oy = int'(ifa.pixel_y); ohs = int'(ifa.h_sync); ovs = int'(ifa.v_sync);
      ode = int'(ifa.display_on); ovb = int'(ifa.vblank); ols = int'(ifa.line_start);
      ofs = int'(ifa.frame_start); ofc = int'(ifa.frame_count);
    end else begin
      p = "b";
      ox = int'(ifb.pixel_x); oy = int'(ifb.pixel_y); ohs = int'(ifb.h_sync); ovs = int'(ifb.v_sync);
      ode = int'(ifb.display_on); ovb = int'(ifb.vblank); ols = int'(ifb.line_start);
      ofs = int'(ifb.frame_start); ofc = int'(ifb.frame_count);
    end
    check_eq({p, ".pixel_x"}, ox, ex);
    check_eq({p, ".pixel_y"}, oy, ey);
    check_eq({p, ".h_sync"}, ohs, ehs);
    check_eq({p, ".v_sync"}, ovs, evs);
    check_eq({p, ".display_on"}, ode, ede);
    check_eq({p, ".vblank"}, ovb, evb);
    check_eq({p, ".line_start"}, ols, m_ls[d]);
    check_eq({p, ".frame_start"}, ofs, m_fs[d]);
    check_eq({p, ".frame_count"}, ofc, m_fc[d]);
  endtask

  task automatic step(input bit r, input bit pe);
    run = r;
    pix_en = pe;
    @(posedge clk);
    model_step(0, r, pe);
    model_step(1, r, pe);
    cyc++;
    #1;
    check_dut(0);
    check_dut(1);
    if (exp_period != 0 && ifa.line_start) begin
      if (last_ls >= 0) check_eq("a.line_period", cyc - last_ls, exp_period);
      last_ls = cyc;
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_dut(0);
    check_dut(1);
    #8 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Continuous run: 257 tiny frames -> count wraps 255 -> 0 -> 1.
    exp_period = 800;
    last_ls = -1;
    for (int i = 0; i < 256 * 48 + 1; i++) step(1'b1, 1'b1);
    exp_period = 0;
    check_eq("b.fc_after_257", int'(ifb.frame_count), 1);
    check_eq("b.fs_at_wrap", int'(ifb.frame_start), 1);

    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0);

    // Half-rate pixel enable: every pixel held two clocks.
    step(1'b0, 1'b0);
    exp_period = 1600;
    last_ls = -1;
    for (int i = 0; i < 4000; i++) step(1'b1, (i % 2) == 0);
    exp_period = 0;

    step(1'b0, 1'b1);
    check_eq("a.stop_display_on", int'(ifa.display_on), 0);
    step(1'b1, 1'b1);
    check_eq("a.restart_frame_start", int'(ifa.frame_start), 1);

    // Asynchronous reset in the middle of horizontal sync.
    step(1'b0, 1'b1);
    for (int i = 0; i < 701; i++) step(1'b1, 1'b1);
    check_eq("a.x_before_reset", int'(ifa.pixel_x), 700);
    check_eq("a.hsync_before_reset", int'(ifa.h_sync), 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    check_eq("a.post_reset_frame_start", int'(ifa.frame_start), 1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
